mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be as listed below.
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 inst_needed  input  1  instruction-cache fetch request.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_available  output  1  one-cycle pulse: inst_o valid.
REQ-007 inst_o  output  32  fetched word, little-endian.
REQ-008 data_needed  input  1  MEM-stage load/store request.
REQ-009 data_we  input  1  1 = store, 0 = load.
REQ-010 data_width  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-011 data_addr  input  32  load/store byte address.
REQ-012 data_wdata  input  32  store data, low bytes used first.
REQ-013 data_available  output  1  one-cycle pulse: load data valid or store complete.
REQ-014 data_rdata  output  32  load result, zero-extended.
REQ-015 mem_a  output  32  RAM byte address, registered.
REQ-016 mem_dout  output  8  RAM write byte, registered.
REQ-017 mem_wr  output  1  RAM write enable, registered.
REQ-018 mem_din  input  8  RAM read byte; the byte addressed in cycle n is valid in cycle n+1.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-020 In IDLE, at an edge with data_needed=1, the block SHALL latch data_addr, data_we, data_width and data_wdata, set the byte count N (1/2/4), and enter WRITE if data_we=1, else READ.
REQ-021 In IDLE with data_needed=0 and inst_needed=1, the block SHALL latch inst_addr with N=4 and enter READ (fetch).
REQ-022 Simultaneous requests: data SHALL win; the fetch SHALL be accepted no earlier than the edge after DONE.
REQ-023 Requests arriving while not in IDLE SHALL be ignored, and input changes after acceptance SHALL have no effect.
REQ-024 READ: during cycles 1..N after acceptance, mem_a SHALL equal base+k (k = 0..N-1) with mem_wr=0.
REQ-025 READ: byte k SHALL be sampled from mem_din at the end of cycle k+2 into result bits [8k+7:8k]; unread upper bytes SHALL be 0.
REQ-026 WRITE: during cycles 1..N, mem_a SHALL equal base+k, mem_dout SHALL equal wdata[8k+7:8k] and mem_wr SHALL be 1.
REQ-027 After the last read sample or last write cycle, the FSM SHALL enter DONE for exactly one cycle, asserting the matching *_available, then return to IDLE.
REQ-028 Latency from the accepting edge to the available cycle SHALL be:
- word read: cycle 6; half read: cycle 4; byte read: cycle 3
- word write: cycle 5; half write: cycle 3; byte write: cycle 2
REQ-029 inst_o and data_rdata SHALL update only on their own completion and hold otherwise.
REQ-030 The requester SHALL drop *_needed in its available cycle; if it is still high in the next IDLE cycle, a new transaction SHALL start.
REQ-031 Address arithmetic SHALL be 32-bit modular: base 0xFFFFFFFF wraps to 0x00000000.
REQ-032 Outside READ/WRITE, mem_wr SHALL be 0, mem_a SHALL be 0 and mem_dout SHALL be 0.

Reset
REQ-033 While rst=0, all outputs SHALL be 0 and the FSM SHALL be IDLE, regardless of clk.
REQ-034 Reset asserted mid-transaction SHALL abort it with no available pulse and no further mem_wr; after release, the block SHALL accept requests from the first edge.

Verification
REQ-035 Fetch: RAM[0x100..0x103]=13,05,00,00 and inst_needed at 0x100 -> mem_a runs 0x100..0x103, inst_available is high only in cycle 6, inst_o=0x00000513.
REQ-036 Collision: inst_needed and a data load (half) at 0x200 in the same cycle, RAM=0xEF,0xBE -> data_available in cycle 4 with data_rdata=0x0000BEEF, then the fetch runs and inst_available follows.
REQ-037 Store word 0xDEADBEEF to 0x300 -> mem_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x300..0x303, data_available in cycle 5, RAM readback matches.
REQ-038 Byte load at 0xFFFFFFFF, then half load at 0xFFFFFFFF -> the byte read completes in cycle 3; the half read's second byte is addressed at 0x00000000.
REQ-039 rst=0 during cycle 3 of a word store -> mem_wr drops immediately, no data_available, only 2 bytes are written, and the next fetch completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns word/half/byte fetches, loads and stores
// into a sequence of single-byte RAM accesses with a one-cycle read latency.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_needed,
    input  logic [31:0] inst_addr,
    output logic        inst_available,
    output logic [31:0] inst_o,
    input  logic        data_needed,
    input  logic        data_we,
    input  logic [1:0]  data_width,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_available,
    output logic [31:0] data_rdata,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] result;
    logic [31:0] merged;
    logic [2:0]  nbytes;
    logic [2:0]  data_n;
    logic [2:0]  cyc;
    logic [1:0]  samp_idx;
    logic        is_fetch;
    logic        last_sample;
    logic        last_write;

    // cyc numbers the cycles after acceptance (1 = first RAM access cycle)
    assign samp_idx    = 2'(cyc - 3'd2);
    assign last_sample = (cyc == nbytes + 3'd1);
    assign last_write  = (cyc == nbytes);

    assign inst_available = (state == DONE) && is_fetch;
    assign data_available = (state == DONE) && !is_fetch;

    always_comb begin
        data_n = 3'd4;
        case (data_width)
            2'd0:    data_n = 3'd1;
            2'd1:    data_n = 3'd2;
            default: data_n = 3'd4;
        endcase
    end

    // Byte addressed in cycle k+1 arrives on mem_din in cycle k+2
    always_comb begin
        merged = result;
        merged[{samp_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_needed)      state_next = data_we ? WRITE : READ;
                else if (inst_needed) state_next = READ;
            end
            READ:    if (last_sample) state_next = DONE;
            WRITE:   if (last_write)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base       <= '0;
            wdata      <= '0;
            result     <= '0;
            nbytes     <= '0;
            cyc        <= '0;
            is_fetch   <= 1'b0;
            inst_o     <= '0;
            data_rdata <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_a    <= '0;
                    mem_dout <= '0;
                    mem_wr   <= 1'b0;
                    if (data_needed) begin
                        base     <= data_addr;
                        wdata    <= data_wdata;
                        nbytes   <= data_n;
                        is_fetch <= 1'b0;
                        cyc      <= 3'd1;
                        result   <= '0;
                        mem_a    <= data_addr;
                        if (data_we) begin
                            mem_dout <= data_wdata[7:0];
                            mem_wr   <= 1'b1;
                        end
                    end else if (inst_needed) begin
                        base     <= inst_addr;
                        nbytes   <= 3'd4;
                        is_fetch <= 1'b1;
                        cyc      <= 3'd1;
                        result   <= '0;
                        mem_a    <= inst_addr;
                    end
                end
                READ: begin
                    cyc <= cyc + 3'd1;
                    if (cyc < nbytes) mem_a <= base + 32'(cyc);
                    else              mem_a <= '0;
                    if (cyc >= 3'd2) result <= merged;
                    if (last_sample) begin
                        if (is_fetch) inst_o     <= merged;
                        else          data_rdata <= merged;
                    end
                end
                WRITE: begin
                    cyc <= cyc + 3'd1;
                    if (cyc < nbytes) begin
                        mem_a    <= base + 32'(cyc);
                        mem_dout <= wdata[{cyc[1:0], 3'b000} +: 8];
                        mem_wr   <= 1'b1;
                    end else begin
                        mem_a    <= '0;
                        mem_dout <= '0;
                        mem_wr   <= 1'b0;
                    end
                end
                default: begin
                    mem_a    <= '0;
                    mem_dout <= '0;
                    mem_wr   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: byte-wide RAM model plus a transaction-level
// reference memory that predicts addresses, bytes, latency and results.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_needed = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_available;
    logic [31:0] inst_o;
    logic        data_needed = 1'b0;
    logic        data_we = 1'b0;
    logic [1:0]  data_width = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_available;
    logic [31:0] data_rdata;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = '0;

    int total = 0;
    int bad = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_inst = '0;
    logic [31:0] exp_rdata = '0;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .inst_needed(inst_needed), .inst_addr(inst_addr),
        .inst_available(inst_available), .inst_o(inst_o),
        .data_needed(data_needed), .data_we(data_we), .data_width(data_width),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_available(data_available), .data_rdata(data_rdata),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one cycle after the address
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int bytes_of(input bit fetch, input logic [1:0] w);
        if (fetch) return 4;
        if (w == 2'd0) return 1;
        if (w == 2'd1) return 2;
        return 4;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mem_a"}, mem_a, 32'h0);
        check_eq({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
        check_eq({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    endtask

    task automatic scramble_inputs();
        inst_needed = 1'b0;
        data_needed = 1'b0;
        inst_addr   = $urandom;
        data_addr   = $urandom;
        data_wdata  = $urandom;
        data_width  = 2'($urandom_range(0, 3));
        data_we     = 1'($urandom_range(0, 1));
    endtask

    // One complete transaction, started from an IDLE cycle
    task automatic run_txn(input bit fetch, input bit we, input logic [1:0] width,
                           input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int n, lat, lat_exp;
        logic [31:0] exp_val;
        bit is_wr;
        n       = bytes_of(fetch, width);
        is_wr   = !fetch && we;
        lat_exp = is_wr ? n + 1 : n + 2;
        exp_val = '0;
        for (int k = 0; k < n; k++) exp_val[8*k +: 8] = ref_rd(addr + 32'(k));

        @(negedge clk);
        check_eq({tag, "_pulse_low"}, 32'(inst_available | data_available), 32'h0);
        if (fetch) begin
            inst_needed = 1'b1;
            inst_addr   = addr;
            data_needed = 1'b0;
        end else begin
            inst_needed = 1'b0;
            data_needed = 1'b1;
            data_we     = we;
            data_width  = width;
            data_addr   = addr;
            data_wdata  = wd;
        end
        @(posedge clk);
        #1 scramble_inputs();

        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= n) begin
                check_eq({tag, "_addr"}, mem_a, addr + 32'(c - 1));
                check_eq({tag, "_wr"}, 32'(mem_wr), 32'(is_wr));
                if (is_wr) check_eq({tag, "_dout"}, 32'(mem_dout), 32'(wd[8*(c-1) +: 8]));
            end else begin
                check_eq({tag, "_wr_off"}, 32'(mem_wr), 32'h0);
            end
            if (inst_available || data_available) begin
                lat = c;
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        if (lat != 0) begin
            check_eq({tag, "_inst_avail"}, 32'(inst_available), 32'(fetch));
            check_eq({tag, "_data_avail"}, 32'(data_available), 32'(!fetch));
            check_idle_outputs({tag, "_done"});
        end
        if (fetch) exp_inst = exp_val;
        else if (!we) exp_rdata = exp_val;
        if (is_wr) for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
        check_eq({tag, "_inst_o"}, inst_o, exp_inst);
        check_eq({tag, "_data_rdata"}, data_rdata, exp_rdata);
    endtask

    task automatic collision_test();
        int lat_d, lat_i;
        preload(32'h200, 8'hEF);
        preload(32'h201, 8'hBE);
        @(negedge clk);
        inst_needed = 1'b1;
        inst_addr   = 32'h100;
        data_needed = 1'b1;
        data_we     = 1'b0;
        data_width  = 2'd1;
        data_addr   = 32'h200;
        @(posedge clk);
        #1 data_needed = 1'b0;
        data_addr = $urandom;
        lat_d = 0;
        lat_i = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (data_available && lat_d == 0) begin
                lat_d = c;
                check_eq("coll_rdata", data_rdata, 32'h0000BEEF);
                check_eq("coll_no_inst", 32'(inst_available), 32'h0);
            end
            if (inst_available) begin
                lat_i = c;
                inst_needed = 1'b0;
                break;
            end
        end
        inst_needed = 1'b0;
        check_eq("coll_data_lat", 32'(lat_d), 32'd4);
        check_eq("coll_inst_seen", 32'(lat_i != 0), 32'h1);
        check_eq("coll_inst_late", 32'(lat_i >= 10), 32'h1);
        exp_rdata = 32'h0000BEEF;
        exp_inst  = 32'h00000513;
        check_eq("coll_inst_o", inst_o, exp_inst);
    endtask

    task automatic reset_mid_store();
        for (int k = 0; k < 4; k++) preload(32'h400 + 32'(k), 8'(8'h11 * (k + 1)));
        @(negedge clk);
        data_needed = 1'b1;
        data_we     = 1'b1;
        data_width  = 2'd2;
        data_addr   = 32'h400;
        data_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1 scramble_inputs();
        @(negedge clk);
        check_eq("rst_c1_addr", mem_a, 32'h400);
        @(negedge clk);
        check_eq("rst_c2_addr", mem_a, 32'h401);
        check_eq("rst_c2_wr", 32'(mem_wr), 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("rst_now");
        check_eq("rst_now_avail", 32'(data_available | inst_available), 32'h0);
        check_eq("rst_now_rdata", data_rdata, 32'h0);
        check_eq("rst_now_inst", inst_o, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_hold_avail", 32'(data_available), 32'h0);
            check_eq("rst_hold_wr", 32'(mem_wr), 32'h0);
        end
        rst = 1'b1;
        ref_mem[32'h400] = 8'hEF;
        ref_mem[32'h401] = 8'hBE;
        exp_inst  = '0;
        exp_rdata = '0;
        run_txn(1'b0, 1'b0, 2'd2, 32'h400, '0, "rst_readback");
        check_eq("rst_readback_val", data_rdata, 32'h4433BEEF);
        run_txn(1'b1, 1'b0, 2'd0, 32'h100, '0, "rst_fetch");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_avail", 32'(inst_available | data_available), 32'h0);
        check_eq("reset_inst_o", inst_o, 32'h0);
        check_eq("reset_rdata", data_rdata, 32'h0);
        rst = 1'b1;

        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h102, 8'h00);
        preload(32'h103, 8'h00);
        run_txn(1'b1, 1'b0, 2'd0, 32'h100, '0, "fetch");
        check_eq("fetch_word", inst_o, 32'h00000513);

        collision_test();

        run_txn(1'b0, 1'b1, 2'd2, 32'h300, 32'hDEADBEEF, "store_w");
        run_txn(1'b0, 1'b0, 2'd2, 32'h300, '0, "store_rb");
        check_eq("store_rb_val", data_rdata, 32'hDEADBEEF);

        preload(32'hFFFFFFFF, 8'hA5);
        preload(32'h00000000, 8'h5A);
        run_txn(1'b0, 1'b0, 2'd0, 32'hFFFFFFFF, '0, "wrap_byte");
        run_txn(1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, '0, "wrap_half");
        check_eq("wrap_half_val", data_rdata, 32'h00005AA5);

        reset_mid_store();

        for (int i = 0; i < 16; i++) preload(32'hFFFFFFF0 + 32'(i), 8'($urandom));
        for (int i = 0; i < 64; i++) preload(32'h1000 + 32'(i), 8'($urandom));
        for (int t = 0; t < 60; t++) begin
            int kind, region;
            logic [31:0] a;
            kind   = $urandom_range(0, 2);
            region = $urandom_range(0, 2);
            if (region == 0)      a = 32'h1000 + 32'($urandom_range(0, 63));
            else if (region == 1) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else                  a = 32'h00000000 + 32'($urandom_range(0, 7));
            run_txn(kind == 0, kind == 2, 2'($urandom_range(0, 3)), a, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
